// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction, hands it to the datapath,
// then advances pc sequentially or to a branch target until halted or faulted.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC   = 32'h0100_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instret_q, instret_d;
    logic [31:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               imem_req_q, imem_req_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [31:0]        next_pc;

    // Next-state, pc and counter update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        next_pc   = br_taken ? br_target : pc_q + 32'd4;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // An ack arriving in the same cycle the limit is reached still wins
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        if (halt_req) begin
                            state_d = S_HALT;
                        end else if (run) begin
                            state_d = S_FETCH;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_EXEC) && (state_q != S_EXEC);
        halted_d      = (state_d == S_HALT);
        fault_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VEC;
            instret_q     <= '0;
            instr_q       <= '0;
            cnt_q         <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instret_q     <= instret_d;
            instr_q       <= instr_d;
            cnt_q         <= cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign instret     = instret_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetches and instructions are queued
// by the stimulus and checked by a monitor when the DUT presents them.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0100_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instret;
    } fetch_exp_t;

    logic        clk = 1'b0;
    logic        rst, run, halt_req, imem_ack, exec_done, br_taken;
    logic [31:0] imem_rdata, br_target;
    logic        imem_req, instr_valid, halted, fault;
    logic [31:0] imem_addr, instr, pc, instret;
    logic        w_imem_req, w_instr_valid, w_halted, w_fault;
    logic [31:0] w_imem_addr, w_instr, w_pc, w_instret;

    fetch_exp_t  fetch_q[$];
    logic [31:0] instr_exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .instret(instret), .halted(halted), .fault(fault)
    );

    // Same stimulus, reset vector at the top of the address space for pc wrap
    pc_sequencer #(.RESET_VEC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(w_instr), .instr_valid(w_instr_valid),
        .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
        .pc(w_pc), .instret(w_instret), .halted(w_halted), .fault(w_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Answer the current fetch after lat wait cycles
    task automatic do_fetch(input int lat, input logic [31:0] data);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (imem_req !== 1'b1) chk("fetch_wait_timeout", 32'(imem_req), 32'd1);
        repeat (lat) tick();
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic do_exec(input int wait_cyc, input logic taken, input logic [31:0] tgt);
        repeat (wait_cyc) tick();
        exec_done = 1'b1;
        br_taken  = taken;
        br_target = tgt;
        tick();
        exec_done = 1'b0;
        br_taken  = 1'b0;
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] n);
        fetch_exp_t e;
        e.addr    = a;
        e.instret = n;
        fetch_q.push_back(e);
    endtask

    // Monitor: each new fetch request and each instr_valid pulse pops an expectation
    initial begin : monitor
        logic prev_req;
        fetch_exp_t e;
        logic [31:0] ei;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && prev_req !== 1'b1) begin
                if (fetch_q.size() == 0) begin
                    chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = fetch_q.pop_front();
                    chk("fetch_addr", imem_addr, e.addr);
                    chk("fetch_pc", pc, e.addr);
                    chk("fetch_instret", instret, e.instret);
                end
            end
            if (instr_valid === 1'b1) begin
                if (instr_exp_q.size() == 0) begin
                    chk("unexpected_instr_valid", instr, 32'hFFFF_FFFF);
                end else begin
                    ei = instr_exp_q.pop_front();
                    chk("instr_data", instr, ei);
                end
            end
            prev_req = imem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        exec_done = 1'b0; br_taken = 1'b0; imem_rdata = '0; br_target = '0;
        tick();
        tick();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pc", pc, RV);
        chk("rst_instret", instret, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        rst = 1'b0;

        // Sequential retire, ack after two wait cycles
        push_fetch(RV, 32'd0);
        run = 1'b1;
        tick();
        instr_exp_q.push_back(32'h1300_0001);
        do_fetch(2, 32'h1300_0001);
        push_fetch(32'h0100_0004, 32'd1);
        do_exec(0, 1'b0, 32'h0);
        chk("seq_pc", pc, 32'h0100_0004);
        chk("seq_instret", instret, 32'd1);
        chk("wrap_pc_to_zero", w_pc, 32'h0000_0000);

        // Taken branch, zero-wait fetch
        instr_exp_q.push_back(32'h1300_0002);
        do_fetch(0, 32'h1300_0002);
        push_fetch(32'h0100_0100, 32'd2);
        do_exec(1, 1'b1, 32'h0100_0100);
        chk("br_pc", pc, 32'h0100_0100);

        // Halt request wins over run
        instr_exp_q.push_back(32'h1300_0003);
        do_fetch(1, 32'h1300_0003);
        halt_req = 1'b1;
        do_exec(0, 1'b0, 32'h0);
        halt_req = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'h0100_0104);
        chk("halt_instret", instret, 32'd3);
        chk("halt_fault", 32'(fault), 32'd0);
        repeat (4) tick();
        chk("halt_no_req", 32'(imem_req), 32'd0);
        chk("halt_absorbing", 32'(halted), 32'd1);
        do_reset();
        chk("halt_rst_pc", pc, RV);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_instret", instret, 32'd0);
        tick();
        chk("halt_rst_idle", 32'(imem_req), 32'd0);

        // Misaligned branch target faults without retiring
        push_fetch(RV, 32'd0);
        run = 1'b1;
        tick();
        instr_exp_q.push_back(32'h1300_0004);
        do_fetch(0, 32'h1300_0004);
        do_exec(0, 1'b1, 32'h0100_0102);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_pc", pc, RV);
        chk("mis_instret", instret, 32'd0);
        chk("mis_instr_stable", instr, 32'h1300_0004);
        chk("mis_wrap_pc", w_pc, 32'hFFFF_FFFC);
        repeat (3) tick();
        chk("mis_no_req", 32'(imem_req), 32'd0);
        chk("mis_absorbing", 32'(fault), 32'd1);
        do_reset();

        // Ack never arrives: fault after exactly 16 fetch cycles
        push_fetch(RV, 32'd0);
        run = 1'b1;
        tick();
        repeat (15) tick();
        chk("to_cycle16_fault", 32'(fault), 32'd0);
        chk("to_cycle16_req", 32'(imem_req), 32'd1);
        tick();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_fault_req", 32'(imem_req), 32'd0);
        do_reset();

        // Ack on the 16th cycle wins; run dropped mid-fetch does not abort it
        push_fetch(RV, 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        instr_exp_q.push_back(32'h1300_0005);
        do_fetch(15, 32'h1300_0005);
        chk("ack16_no_fault", 32'(fault), 32'd0);
        do_exec(0, 1'b0, 32'h0);
        chk("ack16_pc", pc, 32'h0100_0004);
        chk("ack16_instret", instret, 32'd1);
        tick();
        chk("ack16_idle", 32'(imem_req), 32'd0);
        do_reset();

        // Reset mid-fetch, late ack in IDLE is ignored
        push_fetch(RV, 32'd0);
        run = 1'b1;
        tick();
        rst = 1'b1;
        run = 1'b0;
        tick();
        rst = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        tick();
        chk("late_ack_instr", instr, 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd0);
        chk("late_ack_pc", pc, RV);

        tick();
        chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
        chk("instr_queue_drained", 32'(instr_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
